// File: rtl/rv32i_csr_file_pkg.sv
// rv32i_csr_file_pkg
// Shared constants for the machine-mode CSR file: bus widths, CSR addresses,
// mstatus bit positions, and address-decode helpers used by the top level.
package rv32i_csr_file_pkg;

    localparam int CSR_ADDR_BUS = 12;
    localparam int DATA_BUS     = 32;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MISA     = 12'h301;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH= 12'hB82;
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_INSTRET  = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH = 12'hC82;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    function automatic logic csr_implemented(input logic [11:0] addr);
        logic hit;
        hit = 1'b0;
        case (addr)
            CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH,
            CSR_MEPC, CSR_MCAUSE, CSR_MTVAL, CSR_MIP,
            CSR_MCYCLE, CSR_MINSTRET, CSR_MCYCLEH, CSR_MINSTRETH,
            CSR_CYCLE, CSR_INSTRET, CSR_CYCLEH, CSR_INSTRETH,
            CSR_MHARTID: hit = 1'b1;
            default:     hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Address bits 11:10 == 2'b11 mark the architectural read-only space;
    // misa is read-only here as well.
    function automatic logic csr_readonly(input logic [11:0] addr);
        return (addr[11:10] == 2'b11) || (addr == CSR_MISA);
    endfunction

endpackage

// File: rtl/rv32i_csr_file_if.sv
// rv32i_csr_file_if
// CSR access bus between the EX system unit (master) and the CSR file (slave).
//   csr_raddr/csr_rdata/csr_illegal : combinational read port + legality flag
//   csr_we/csr_waddr/csr_wdata      : write port, data already RW/RS/RC-merged
interface rv32i_csr_file_if;
    import rv32i_csr_file_pkg::*;

    logic [CSR_ADDR_BUS-1:0] csr_raddr;
    logic [DATA_BUS-1:0]     csr_rdata;
    logic                    csr_illegal;
    logic                    csr_we;
    logic [CSR_ADDR_BUS-1:0] csr_waddr;
    logic [DATA_BUS-1:0]     csr_wdata;

    modport master (
        output csr_raddr, csr_we, csr_waddr, csr_wdata,
        input  csr_rdata, csr_illegal
    );

    modport slave (
        input  csr_raddr, csr_we, csr_waddr, csr_wdata,
        output csr_rdata, csr_illegal
    );
endinterface

// File: rtl/rv32i_csr_counter64.sv
// rv32i_csr_counter64
// 64-bit free-running counter with increment enable and 32-bit half writes.
//   clk, rst  : clock, asynchronous active-low reset
//   inc       : count up by one this cycle
//   we_lo/hi  : load wdata into the low/high word; suppresses the increment
//   count     : current 64-bit value
module rv32i_csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        we_lo,
    input  logic        we_hi,
    input  logic [31:0] wdata,
    output logic [63:0] count
);

    // A write to either half freezes the other half for that cycle, so
    // software can load the counter in two steps without a stray carry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       count         <= 64'd0;
        else if (we_lo) count[31:0]   <= wdata;
        else if (we_hi) count[63:32]  <= wdata;
        else if (inc)   count         <= count + 64'd1;
    end

endmodule

// File: rtl/rv32i_csr_file.sv
// rv32i_csr_file
// RV32I machine-mode CSR file with mcycle/minstret counters and trap/MRET
// handling.
//   clk, rst          : clock, asynchronous active-low reset
//   csr               : CSR read/write bus (slave side)
//   instret           : one instruction retired this cycle
//   trap_valid/cause/pc/val : trap entry this cycle and its details
//   mret_valid        : MRET retiring this cycle
//   mtvec_o, mepc_o   : trap vector and return PC, straight from registers
//   mie_global        : mstatus.MIE
module rv32i_csr_file
    import rv32i_csr_file_pkg::*;
#(
    parameter logic [31:0] MISA_VALUE = 32'h4000_0100,
    parameter logic [31:0] HART_ID    = 32'h0
) (
    input  logic                clk,
    input  logic                rst,
    rv32i_csr_file_if.slave     csr,
    input  logic                instret,
    input  logic                trap_valid,
    input  logic [DATA_BUS-1:0] trap_cause,
    input  logic [DATA_BUS-1:0] trap_pc,
    input  logic [DATA_BUS-1:0] trap_val,
    input  logic                mret_valid,
    output logic [DATA_BUS-1:0] mtvec_o,
    output logic [DATA_BUS-1:0] mepc_o,
    output logic                mie_global
);

    logic        mpie;
    logic [31:0] mie_en;
    logic [31:0] mscratch;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic [63:0] mcycle;
    logic [63:0] minstret;
    logic        wr_ok;
    logic [31:0] mstatus;

    assign wr_ok = csr.csr_we && csr_implemented(csr.csr_waddr)
                   && !csr_readonly(csr.csr_waddr);

    assign csr.csr_illegal = !csr_implemented(csr.csr_raddr)
                             || (csr.csr_we && !wr_ok);

    // MPP is hardwired to machine mode.
    always_comb begin
        mstatus               = 32'd0;
        mstatus[12:11]        = 2'b11;
        mstatus[MSTATUS_MPIE] = mpie;
        mstatus[MSTATUS_MIE]  = mie_global;
    end

    // Trap owns mstatus/mepc/mcause/mtval, MRET owns mstatus; a CSR write to
    // a register claimed by a higher-priority event that cycle is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mie_global <= 1'b0;
            mpie       <= 1'b0;
            mie_en     <= 32'd0;
            mtvec_o    <= 32'd0;
            mscratch   <= 32'd0;
            mepc_o     <= 32'd0;
            mcause     <= 32'd0;
            mtval      <= 32'd0;
        end else begin
            if (trap_valid) begin
                mpie       <= mie_global;
                mie_global <= 1'b0;
                mepc_o     <= {trap_pc[31:2], 2'b00};
                mcause     <= trap_cause;
                mtval      <= trap_val;
            end else begin
                if (mret_valid) begin
                    mie_global <= mpie;
                    mpie       <= 1'b1;
                end else if (wr_ok && csr.csr_waddr == CSR_MSTATUS) begin
                    mie_global <= csr.csr_wdata[MSTATUS_MIE];
                    mpie       <= csr.csr_wdata[MSTATUS_MPIE];
                end
                if (wr_ok && csr.csr_waddr == CSR_MEPC)   mepc_o <= {csr.csr_wdata[31:2], 2'b00};
                if (wr_ok && csr.csr_waddr == CSR_MCAUSE) mcause <= csr.csr_wdata;
                if (wr_ok && csr.csr_waddr == CSR_MTVAL)  mtval  <= csr.csr_wdata;
            end
            if (wr_ok && csr.csr_waddr == CSR_MIE)      mie_en   <= csr.csr_wdata;
            if (wr_ok && csr.csr_waddr == CSR_MTVEC)    mtvec_o  <= {csr.csr_wdata[31:2], 2'b00};
            if (wr_ok && csr.csr_waddr == CSR_MSCRATCH) mscratch <= csr.csr_wdata;
        end
    end

    rv32i_csr_counter64 u_mcycle (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .we_lo (wr_ok && csr.csr_waddr == CSR_MCYCLE),
        .we_hi (wr_ok && csr.csr_waddr == CSR_MCYCLEH),
        .wdata (csr.csr_wdata),
        .count (mcycle)
    );

    rv32i_csr_counter64 u_minstret (
        .clk   (clk),
        .rst   (rst),
        .inc   (instret),
        .we_lo (wr_ok && csr.csr_waddr == CSR_MINSTRET),
        .we_hi (wr_ok && csr.csr_waddr == CSR_MINSTRETH),
        .wdata (csr.csr_wdata),
        .count (minstret)
    );

    // Stored values only; a same-cycle write is not forwarded.
    always_comb begin
        csr.csr_rdata = 32'd0;
        case (csr.csr_raddr)
            CSR_MSTATUS:                csr.csr_rdata = mstatus;
            CSR_MISA:                   csr.csr_rdata = MISA_VALUE;
            CSR_MIE:                    csr.csr_rdata = mie_en;
            CSR_MTVEC:                  csr.csr_rdata = mtvec_o;
            CSR_MSCRATCH:               csr.csr_rdata = mscratch;
            CSR_MEPC:                   csr.csr_rdata = mepc_o;
            CSR_MCAUSE:                 csr.csr_rdata = mcause;
            CSR_MTVAL:                  csr.csr_rdata = mtval;
            CSR_MIP:                    csr.csr_rdata = 32'd0;
            CSR_MCYCLE,   CSR_CYCLE:    csr.csr_rdata = mcycle[31:0];
            CSR_MCYCLEH,  CSR_CYCLEH:   csr.csr_rdata = mcycle[63:32];
            CSR_MINSTRET, CSR_INSTRET:  csr.csr_rdata = minstret[31:0];
            CSR_MINSTRETH,CSR_INSTRETH: csr.csr_rdata = minstret[63:32];
            CSR_MHARTID:                csr.csr_rdata = HART_ID;
            default:                    csr.csr_rdata = 32'd0;
        endcase
    end

endmodule

// File: doc/rv32i_csr_file.md
RV32I_CSR_FILE -- requirements
Module: rv32i_csr_file

Interface
REQ-001 SHALL have parameter MISA_VALUE, default 32'h4000_0100, the read-only misa contents (RV32I).
REQ-002 SHALL have parameter HART_ID, default 32'h0, the read-only mhartid contents.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port csr_raddr  input  12  read address from decode/EX.
REQ-006 SHALL have port csr_rdata  output  32  read data, combinational.
REQ-007 SHALL have port csr_illegal  output  1  csr_raddr is unimplemented, or csr_we targets an unimplemented or read-only CSR.
REQ-008 SHALL have port csr_we  input  1  write enable from the EX system unit.
REQ-009 SHALL have port csr_waddr  input  12  write address.
REQ-010 SHALL have port csr_wdata  input  32  write data, already merged by EX (RW/RS/RC).
REQ-011 SHALL have port instret  input  1  one instruction retired this cycle.
REQ-012 SHALL have port trap_valid  input  1  trap entry this cycle.
REQ-013 SHALL have ports trap_cause  input  32, trap_pc  input  32, trap_val  input  32, giving the trap cause, faulting PC and trap value.
REQ-014 SHALL have port mret_valid  input  1  MRET retiring this cycle.
REQ-015 SHALL have ports mtvec_o  output  32, mepc_o  output  32, mie_global  output  1 (mstatus.MIE), all driven directly from registers.

Function
REQ-016 SHALL implement mstatus 0x300 (only MIE bit 3 and MPIE bit 7 writable; MPP bits 12:11 read 2'b11), misa 0x301 RO, mie 0x304, mtvec 0x305 (bits 1:0 forced 0), mscratch 0x340, mepc 0x341 (bits 1:0 forced 0), mcause 0x342, mtval 0x343, mip 0x344 (reads 0), and mhartid 0xF14 RO.
REQ-017 SHALL implement the 64-bit counters mcycle (0xB00 low, 0xB80 high) and minstret (0xB02 low, 0xB82 high), with read-only user aliases at 0xC00/0xC80 and 0xC02/0xC82.
REQ-018 SHALL increment mcycle by 1 every cycle out of reset, carrying from the low word into the high word, and wrapping 64'hFFFF_FFFF_FFFF_FFFF to 0.
REQ-019 SHALL increment minstret by 1 in each cycle where instret=1, with the same carry and wrap rules.
REQ-020 SHALL suppress the counter increment in any cycle where a CSR write lands on either half of that counter; the written half takes csr_wdata and the other half holds.
REQ-021 SHALL return the stored value on csr_rdata, with no write bypass; the pipeline resolves the hazard.
REQ-022 SHALL return 0 on csr_rdata for unimplemented addresses.
REQ-023 SHALL ignore csr_we to an unimplemented CSR or to a read-only CSR (address bits 11:10 == 2'b11, or misa), and SHALL raise csr_illegal in that cycle.
REQ-024 SHALL, on trap_valid, set mepc=trap_pc, mcause=trap_cause, mtval=trap_val, MPIE=MIE and MIE=0.
REQ-025 SHALL, on mret_valid (without trap_valid), set MIE=MPIE and MPIE=1.
REQ-026 SHALL apply priority trap_valid > mret_valid > csr_we: a lower-priority update to a CSR also touched by a higher-priority event is dropped, while writes to untouched CSRs still occur.
REQ-027 SHALL reflect every update on mtvec_o, mepc_o, mie_global and csr_rdata in the cycle after the clock edge.

Reset
REQ-028 SHALL, on rst=0 and asynchronously, clear every writable CSR and both counters to 0, so that mstatus reads 32'h0000_1800.
REQ-029 SHALL hold mtvec_o=0, mepc_o=0 and mie_global=0 while rst=0.
REQ-030 SHALL perform the first mcycle increment on the first rising edge after rst deasserts.
REQ-031 SHALL, if rst asserts mid-operation, discard any write or trap in flight.

Structure
REQ-032 SHALL take all CSR address constants and mstatus bit positions from the shared DEFINES.v include, alongside the existing CSRAddrBus and DataBus widths.
REQ-033 SHALL instantiate one sub-module, rv32i_csr_counter64 (64-bit counter with increment enable, half-word write and carry), used twice, for mcycle and minstret.

Verification
REQ-034 SHALL cover reset: hold rst=0, then release and run 5 cycles -> mstatus reads 32'h1800 and mcycle low reads 5.
REQ-035 SHALL cover write then read: csr_we to 0x340 with 32'hDEAD_BEEF -> the next cycle, csr_raddr=0x340 returns 32'hDEAD_BEEF; a write to 0x305 with 32'h0000_0103 -> mtvec_o=32'h0000_0100.
REQ-036 SHALL cover counter carry: write 0xB00 with 32'hFFFF_FFFF, then run 1 cycle -> low reads 0 and high (0xB80) reads 1.
REQ-037 SHALL cover trap against a same-cycle write: trap_valid with cause 2 and pc 32'h80, together with csr_we to 0x341 with 32'h44 -> mepc=32'h80, mcause=2, MIE=0.
REQ-038 SHALL cover the trap then MRET sequence: with MIE=1, trap, then mret -> MIE returns to 1 and MPIE=1.
REQ-039 SHALL cover illegal access: csr_we to 0xC00, or csr_raddr=0x7C0 -> csr_illegal=1 and the stored state is unchanged.
